// File: rtl/wb_port_arbiter_if.sv
// Register-file writeback bus shared by the MEM/WB pipe, the long-latency unit and the arbiter.
interface wb_port_arbiter_if;
  logic        pipe_valid;
  logic        pipe_fp_we;
  logic        pipe_int_we;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_fp_wdata;
  logic [31:0] pipe_int_wdata;
  logic        pipe_stall;
  logic        ll_valid;
  logic        ll_ready;
  logic        ll_fp;
  logic [4:0]  ll_rd;
  logic [31:0] ll_wdata;
  logic        ll_busy;
  logic        wb_fp_we;
  logic        wb_int_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_fp_wdata;
  logic [31:0] wb_int_wdata;

  modport master (
    output pipe_valid, pipe_fp_we, pipe_int_we, pipe_rd, pipe_fp_wdata, pipe_int_wdata,
    output ll_valid, ll_fp, ll_rd, ll_wdata,
    input  pipe_stall, ll_ready, ll_busy,
    input  wb_fp_we, wb_int_we, wb_waddr, wb_fp_wdata, wb_int_wdata
  );

  modport slave (
    input  pipe_valid, pipe_fp_we, pipe_int_we, pipe_rd, pipe_fp_wdata, pipe_int_wdata,
    input  ll_valid, ll_fp, ll_rd, ll_wdata,
    output pipe_stall, ll_ready, ll_busy,
    output wb_fp_we, wb_int_we, wb_waddr, wb_fp_wdata, wb_int_wdata
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// INT/FP register-file write-port arbiter: pipe has priority, long-latency results drain from a FIFO.
// Optional performance counters are enabled with the WB_ARB_PERF_EN macro.
module wb_port_arbiter #(
  parameter int unsigned LL_DEPTH     = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  wb_port_arbiter_if.slave  bus
`ifdef WB_ARB_PERF_EN
  ,
  output logic [31:0]       perf_conflict_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  localparam int unsigned PTR_W    = $clog2(LL_DEPTH);
  localparam int unsigned CNT_W    = PTR_W + 1;
  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic        fp;
    logic [4:0]  rd;
    logic [31:0] wdata;
  } ll_entry_t;

  ll_entry_t             fifo_mem [LL_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count, count_d;
  logic [STARVE_W-1:0]   starve_cnt, starve_d;
  logic                  stall_q, stall_d;
  logic                  ready_q, busy_q;
  logic                  fp_we_q, fp_we_d;
  logic                  int_we_q, int_we_d;
  logic [4:0]            waddr_q, waddr_d;
  logic [31:0]           fp_wdata_q, fp_wdata_d;
  logic [31:0]           int_wdata_q, int_wdata_d;
  logic                  grant_pipe_c, nonempty_c, pop_c, push_c;
  ll_entry_t             head_c;

  assign bus.pipe_stall   = stall_q;
  assign bus.ll_ready     = ready_q;
  assign bus.ll_busy      = busy_q;
  assign bus.wb_fp_we     = fp_we_q;
  assign bus.wb_int_we    = int_we_q;
  assign bus.wb_waddr     = waddr_q;
  assign bus.wb_fp_wdata  = fp_wdata_q;
  assign bus.wb_int_wdata = int_wdata_q;

  // Grant selection and next-state for FIFO occupancy, starvation and write ports.
  always_comb begin
    grant_pipe_c = bus.pipe_valid && (bus.pipe_fp_we || bus.pipe_int_we) && !stall_q;
    nonempty_c   = (count != '0);
    pop_c        = !grant_pipe_c && nonempty_c;
    push_c       = bus.ll_valid && ready_q;
    head_c       = fifo_mem[rd_ptr];
    count_d      = count + CNT_W'(push_c) - CNT_W'(pop_c);
    starve_d     = (pop_c || !nonempty_c) ? '0 : starve_cnt + STARVE_W'(1);
    stall_d      = (starve_d == STARVE_W'(STARVE_LIMIT));

    fp_we_d     = 1'b0;
    int_we_d    = 1'b0;
    waddr_d     = waddr_q;
    fp_wdata_d  = fp_wdata_q;
    int_wdata_d = int_wdata_q;
    if (grant_pipe_c) begin
      fp_we_d     = bus.pipe_fp_we;
      int_we_d    = bus.pipe_int_we && (bus.pipe_rd != 5'd0);
      waddr_d     = bus.pipe_rd;
      fp_wdata_d  = bus.pipe_fp_wdata;
      int_wdata_d = bus.pipe_int_wdata;
    end else if (pop_c) begin
      waddr_d = head_c.rd;
      if (head_c.fp) begin
        fp_we_d    = 1'b1;
        fp_wdata_d = head_c.wdata;
      end else begin
        // x0 is hardwired: slot and pop are still consumed
        int_we_d    = (head_c.rd != 5'd0);
        int_wdata_d = head_c.wdata;
      end
    end
  end

  // FIFO storage carries no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push_c) fifo_mem[wr_ptr] <= '{fp: bus.ll_fp, rd: bus.ll_rd, wdata: bus.ll_wdata};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      starve_cnt  <= '0;
      stall_q     <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      fp_we_q     <= 1'b0;
      int_we_q    <= 1'b0;
      waddr_q     <= '0;
      fp_wdata_q  <= '0;
      int_wdata_q <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      count       <= count_d;
      starve_cnt  <= starve_d;
      stall_q     <= stall_d;
      ready_q     <= (count_d != CNT_W'(LL_DEPTH));
      busy_q      <= (count_d != '0);
      fp_we_q     <= fp_we_d;
      int_we_q    <= int_we_d;
      waddr_q     <= waddr_d;
      fp_wdata_q  <= fp_wdata_d;
      int_wdata_q <= int_wdata_d;
    end
  end

`ifdef WB_ARB_PERF_EN
  // Saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_conflict_cnt <= '0;
      perf_stall_cnt    <= '0;
    end else begin
      if (nonempty_c && grant_pipe_c && (perf_conflict_cnt != '1))
        perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
      if (stall_q && (perf_stall_cnt != '1))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: vector table, directed corner sequences and random traffic
// checked against a queue-based reference model.
module tb_wb_port_arbiter;
  localparam int unsigned LL_DEPTH     = 2;
  localparam int unsigned STARVE_LIMIT = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wb_port_arbiter_if bus();
`ifdef WB_ARB_PERF_EN
  logic [31:0] perf_conflict_cnt, perf_stall_cnt;
`endif

  wb_port_arbiter #(.LL_DEPTH(LL_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef WB_ARB_PERF_EN
    ,
    .perf_conflict_cnt (perf_conflict_cnt),
    .perf_stall_cnt    (perf_stall_cnt)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;
  int fp_pulses = 0;

  // Reference model state
  typedef struct packed {
    logic        fp;
    logic [4:0]  rd;
    logic [31:0] data;
  } ll_t;
  ll_t         m_q[$];
  int          m_starve;
  bit          m_stall, m_push, m_fp_we, m_int_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_fdata, m_idata;
  longint      m_conf, m_stc;

  typedef struct {
    logic        pv, fwe, iwe;
    logic [4:0]  rd;
    logic [31:0] fd, id;
    logic        e_fwe, e_iwe;
    logic [4:0]  e_addr;
    logic [31:0] e_fd, e_id;
  } vec_t;
  vec_t vt[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_starve = 0; m_stall = 0; m_push = 0; m_fp_we = 0; m_int_we = 0;
    m_waddr = '0; m_fdata = '0; m_idata = '0; m_conf = 0; m_stc = 0;
  endtask

  // One clock edge of the arbitration rules, applied to the inputs currently on the bus.
  task automatic model_step();
    bit  gp, ne, pop;
    ll_t e;
    gp  = bus.pipe_valid && (bus.pipe_fp_we || bus.pipe_int_we) && !m_stall;
    ne  = m_q.size() != 0;
    pop = !gp && ne;
    m_push = bus.ll_valid && (m_q.size() < LL_DEPTH);
    if (ne && gp) m_conf++;
    if (m_stall) m_stc++;
    m_fp_we = 0; m_int_we = 0;
    if (gp) begin
      m_fp_we  = bus.pipe_fp_we;
      m_int_we = bus.pipe_int_we && bus.pipe_rd != 0;
      m_waddr  = bus.pipe_rd;
      m_fdata  = bus.pipe_fp_wdata;
      m_idata  = bus.pipe_int_wdata;
    end else if (pop) begin
      e = m_q.pop_front();
      m_waddr = e.rd;
      if (e.fp) begin m_fp_we = 1; m_fdata = e.data; end
      else begin m_int_we = (e.rd != 0); m_idata = e.data; end
    end
    if (m_push) begin
      e.fp = bus.ll_fp; e.rd = bus.ll_rd; e.data = bus.ll_wdata;
      m_q.push_back(e);
    end
    m_starve = (pop || !ne) ? 0 : m_starve + 1;
    m_stall  = (m_starve == STARVE_LIMIT);
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_stall"},  32'(bus.pipe_stall),   32'(m_stall));
    chk({tag, "_ready"},  32'(bus.ll_ready),     32'(m_q.size() < LL_DEPTH));
    chk({tag, "_busy"},   32'(bus.ll_busy),      32'(m_q.size() != 0));
    chk({tag, "_fp_we"},  32'(bus.wb_fp_we),     32'(m_fp_we));
    chk({tag, "_int_we"}, 32'(bus.wb_int_we),    32'(m_int_we));
    chk({tag, "_waddr"},  32'(bus.wb_waddr),     32'(m_waddr));
    chk({tag, "_fdata"},  bus.wb_fp_wdata,       m_fdata);
    chk({tag, "_idata"},  bus.wb_int_wdata,      m_idata);
`ifdef WB_ARB_PERF_EN
    chk({tag, "_perf_conf"},  perf_conflict_cnt, 32'(m_conf));
    chk({tag, "_perf_stall"}, perf_stall_cnt,    32'(m_stc));
`endif
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_step();
    #1;
    if (bus.wb_fp_we) fp_pulses++;
    check_all(tag);
  endtask

  task automatic set_pipe(input logic pv, input logic fwe, input logic iwe, input logic [4:0] rd,
                          input logic [31:0] fd, input logic [31:0] id);
    bus.pipe_valid = pv; bus.pipe_fp_we = fwe; bus.pipe_int_we = iwe;
    bus.pipe_rd = rd; bus.pipe_fp_wdata = fd; bus.pipe_int_wdata = id;
  endtask

  task automatic set_ll(input logic v, input logic fp, input logic [4:0] rd, input logic [31:0] d);
    bus.ll_valid = v; bus.ll_fp = fp; bus.ll_rd = rd; bus.ll_wdata = d;
  endtask

  initial begin
    bit done;
    vt[0] = '{1,0,1, 5,  32'h0,        32'h1234,     0,1, 5,  32'h0,        32'h1234};
    vt[1] = '{1,1,0, 7,  32'h3F800000, 32'h0,        1,0, 7,  32'h3F800000, 32'h0};
    vt[2] = '{1,1,1, 9,  32'hAAAA0001, 32'h55550002, 1,1, 9,  32'hAAAA0001, 32'h55550002};
    vt[3] = '{1,0,1, 0,  32'h11,       32'h22,       0,0, 0,  32'h11,       32'h22};
    vt[4] = '{1,1,0, 0,  32'h33,       32'h44,       1,0, 0,  32'h33,       32'h44};
    vt[5] = '{1,0,0, 12, 32'h55,       32'h66,       0,0, 0,  32'h33,       32'h44};
    vt[6] = '{0,1,1, 13, 32'h77,       32'h88,       0,0, 0,  32'h33,       32'h44};
    vt[7] = '{1,0,1, 31, 32'h99,       32'hCAFEF00D, 0,1, 31, 32'h99,       32'hCAFEF00D};

    rst_n = 1'b0;
    set_pipe(0, 0, 0, 0, 0, 0);
    set_ll(0, 0, 0, 0);
    model_reset();
    #12;
    chk("rst_fp_we",  32'(bus.wb_fp_we),   0);
    chk("rst_int_we", 32'(bus.wb_int_we),  0);
    chk("rst_waddr",  32'(bus.wb_waddr),   0);
    chk("rst_fdata",  bus.wb_fp_wdata,     0);
    chk("rst_idata",  bus.wb_int_wdata,    0);
    chk("rst_stall",  32'(bus.pipe_stall), 0);
    chk("rst_ready",  32'(bus.ll_ready),   1);
    chk("rst_busy",   32'(bus.ll_busy),    0);
    rst_n = 1'b1;

    // Single-cycle pipe vectors with an empty FIFO
    for (int i = 0; i < 8; i++) begin
      set_pipe(vt[i].pv, vt[i].fwe, vt[i].iwe, vt[i].rd, vt[i].fd, vt[i].id);
      step("vec");
      chk($sformatf("vec%0d_fp_we", i),  32'(bus.wb_fp_we),  32'(vt[i].e_fwe));
      chk($sformatf("vec%0d_int_we", i), 32'(bus.wb_int_we), 32'(vt[i].e_iwe));
      chk($sformatf("vec%0d_waddr", i),  32'(bus.wb_waddr),  32'(vt[i].e_addr));
      chk($sformatf("vec%0d_fdata", i),  bus.wb_fp_wdata,    vt[i].e_fd);
      chk($sformatf("vec%0d_idata", i),  bus.wb_int_wdata,   vt[i].e_id);
    end

    // LL only, idle pipe: two-cycle latency, busy only in the middle cycle
    set_pipe(0, 0, 0, 0, 0, 0);
    step("idle");
    set_ll(1, 1, 3, 32'h3F800000);
    step("ll1");
    set_ll(0, 0, 0, 0);
    chk("ll_t1_busy",  32'(bus.ll_busy),  1);
    chk("ll_t1_fp_we", 32'(bus.wb_fp_we), 0);
    step("ll2");
    chk("ll_t2_fp_we", 32'(bus.wb_fp_we), 1);
    chk("ll_t2_waddr", 32'(bus.wb_waddr), 3);
    chk("ll_t2_fdata", bus.wb_fp_wdata,   32'h3F800000);
    chk("ll_t2_busy",  32'(bus.ll_busy),  0);

    // LL INT write to x0 is popped without a write enable
    set_ll(1, 0, 0, 32'hDEAD);
    step("ll0a");
    set_ll(0, 0, 0, 0);
    chk("llx0_busy1", 32'(bus.ll_busy), 1);
    step("ll0b");
    chk("llx0_int_we", 32'(bus.wb_int_we), 0);
    chk("llx0_fp_we",  32'(bus.wb_fp_we),  0);
    chk("llx0_busy0",  32'(bus.ll_busy),   0);

    // Starvation: busy pipe, one LL entry
    set_pipe(1, 0, 1, 10, 0, 32'hA);
    set_ll(1, 1, 4, 32'hF00D);
    step("stv");
    set_ll(0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("stv_c%0d_stall", k), 32'(bus.pipe_stall), 0);
      step("stv");
    end
    chk("stv_c5_stall", 32'(bus.pipe_stall), 1);
    step("stv");
    chk("stv_ll_fp_we", 32'(bus.wb_fp_we),   1);
    chk("stv_ll_waddr", 32'(bus.wb_waddr),   4);
    chk("stv_ll_fdata", bus.wb_fp_wdata,     32'hF00D);
    chk("stv_unstall",  32'(bus.pipe_stall), 0);
    step("stv");
    chk("stv_pipe_int_we", 32'(bus.wb_int_we), 1);
    chk("stv_pipe_waddr",  32'(bus.wb_waddr),  10);

    // Full FIFO: third offer held until space, nothing lost or duplicated
    fp_pulses = 0;
    set_pipe(1, 0, 1, 11, 0, 32'hB);
    set_ll(1, 1, 20, 32'h20);
    step("full");
    set_ll(1, 1, 21, 32'h21);
    step("full");
    chk("full_ready0", 32'(bus.ll_ready), 0);
    set_ll(1, 1, 22, 32'h22);
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      step("full");
      done = m_push;
    end
    if (!done) chk("full_accept_timeout", 0, 1);
    set_ll(0, 0, 0, 0);
    set_pipe(0, 0, 0, 0, 0, 0);
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      step("drain");
      done = !bus.ll_busy && m_q.size() == 0;
    end
    if (!done) chk("full_drain_timeout", 0, 1);
    chk("full_fp_writes", 32'(fp_pulses), 3);

    // Reset while holding two entries with pipe_stall asserted
    set_pipe(1, 0, 1, 12, 0, 32'hC);
    set_ll(1, 0, 13, 32'h13);
    step("rmid");
    set_ll(1, 1, 14, 32'h14);
    step("rmid");
    set_ll(0, 0, 0, 0);
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      step("rmid");
      done = bus.pipe_stall;
    end
    if (!done) chk("rmid_stall_timeout", 0, 1);
    chk("rmid_pre_busy", 32'(bus.ll_busy), 1);
    rst_n = 1'b0;
    #1;
    chk("rmid_fp_we",  32'(bus.wb_fp_we),   0);
    chk("rmid_int_we", 32'(bus.wb_int_we),  0);
    chk("rmid_waddr",  32'(bus.wb_waddr),   0);
    chk("rmid_fdata",  bus.wb_fp_wdata,     0);
    chk("rmid_idata",  bus.wb_int_wdata,    0);
    chk("rmid_stall",  32'(bus.pipe_stall), 0);
    chk("rmid_busy",   32'(bus.ll_busy),    0);
    model_reset();
    set_pipe(0, 0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b1;
    #1;
    chk("rmid_ready_after", 32'(bus.ll_ready), 1);
    step("rpost");

    // Random traffic against the reference model
    for (int c = 0; c < 600; c++) begin
      if (!m_stall)
        set_pipe(1'($urandom_range(0, 99) < 60), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), $urandom, $urandom);
      if (!bus.ll_valid || m_push)
        set_ll(1'($urandom_range(0, 99) < 40), 1'($urandom),
               ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), $urandom);
      step("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
